rv_trap_ctrl: RTL and testbench
===============================

Name: rv_trap_ctrl

Overview:
Owns the machine-mode trap CSRs: mstatus, mie, mip, mepc and mcause. It supplies their current values to the CSR read/modify unit. It accepts the CSR write value computed in X and records trap entry and exit for exceptions, interrupts and mret. It also generates the interrupt request to the pipeline from a synchronised external IRQ line and a timer tick.

Parameters:
TRAP_VECTOR, 32'h00000008, address the pipeline jumps to on any trap; driven on x_trap_vector_o.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
x_stall_i  in  1  X stage stalled; no state update
x_kill_i  in  1  X instruction killed; no state update
d_is_csr_i  in  1  instruction in X is a CSR op
d_csr_sel_i  in  12  CSR address of that op
x_csr_write_value_i  in  32  new CSR value from the CSR read/modify unit
x_exception_i  in  1  X instruction raises a synchronous exception
x_exception_cause_i  in  4  exception code
x_pc_i  in  32  PC of the X instruction (exception PC / interrupt resume PC)
x_irq_ack_i  in  1  pipeline takes the pending interrupt this cycle
x_is_mret_i  in  1  X instruction is mret
irq_i  in  1  external interrupt, level, asynchronous
timer_tick_i  in  1  one-cycle timer compare pulse, synchronous
x_irq_o  out  1  interrupt request to pipeline (registered)
x_trap_vector_o  out  32  constant TRAP_VECTOR
csr_mstatus_o  out  32  mstatus value
csr_mie_o  out  32  mie value
csr_mip_o  out  32  mip value
csr_mepc_o  out  32  mepc value
csr_mcause_o  out  32  mcause value

Behaviour:
- CSR addresses: mstatus 0x300, mie 0x304, mepc 0x341, mcause 0x342, mip 0x344. Any other address is ignored.
- mstatus: only MIE[3] and MPIE[7] are implemented; all other bits read 0.
- mie: only MTIE[7] and MEIE[11] are implemented; all other bits read 0.
- mip:
  - MEIP[11] is the output of a 2-flop synchroniser on irq_i and is read-only.
  - MTIP[7] is sticky: set on timer_tick_i, cleared only by a CSR write to mip with bit 7 = 0.
  - Tick and clearing write in the same cycle: the tick wins.
  - All other mip bits read 0.
- mepc: 32-bit register; bits [1:0] are always forced to 0 on write.
- mcause: bit 31 is the interrupt flag, bits [3:0] are the code, all other bits are 0.
- Reset: all CSR state is 0, synchroniser flops are 0, x_irq_o = 0.
- Update enable: en = !x_stall_i && !x_kill_i. No CSR, trap or mret update happens without en. Synchroniser flops and MTIP set are not gated by en.
- Trap entry (en && (x_exception_i || x_irq_ack_i)), all updates on the next edge:
  - mepc <= x_pc_i & ~3.
  - MPIE <= MIE.
  - MIE <= 0.
  - Exception: mcause <= {0, exception code}.
  - Interrupt: mcause <= {1, 11} if MEIP && MEIE is pending, else {1, 7}. External has priority over timer.
  - If x_exception_i and x_irq_ack_i are both set, the exception wins.
- mret (en && x_is_mret_i && no trap entry): MIE <= MPIE; MPIE <= 1.
- CSR write (en && d_is_csr_i && no trap entry && no mret): the selected register loads x_csr_write_value_i, masked to its implemented bits.
- Priority within one cycle: trap entry > mret > CSR write.
- Interrupt request:
  - x_irq_o is registered: x_irq_o <= MIE && |(mip & mie), evaluated on current register values each cycle.
  - Latency: irq_i rising edge to MEIP = 2 cycles; MEIP to x_irq_o = 1 more cycle.
  - After an interrupt is taken, MIE = 0, so x_irq_o drops one cycle after MIE clears.
  - While x_stall_i is high, x_irq_o still updates from current state.
  - x_irq_ack_i without x_irq_o is a protocol error; it is still treated as an interrupt entry.
- Reset mid-operation clears everything, including the pending MTIP, on the same edge.
- All csr_*_o outputs are taken directly from the registers; no combinational path from inputs.

Test Plan:
1. Reset, then CSR write 0xFFFFFFFF to mstatus, mie, mepc and mip: read back mstatus 0x88, mie 0x880, mepc 0xFFFFFFFC, mip 0x0.
2. mstatus=0x8, mie=0x800, then irq_i=1: MEIP visible at cycle 2, x_irq_o=1 at cycle 3. Pulse x_irq_ack_i with x_pc_i=0x1236: mepc=0x1234, mcause=0x8000000B, mstatus=0x80, x_irq_o=0 one cycle later.
3. Exception with cause 2 and PC 0x100, with x_irq_ack_i asserted in the same cycle: mcause=0x00000002, mepc=0x100. Then mret: mstatus=0x88 if MIE was 1 before the trap.
4. With timer_tick_i pulsed and MTIE+MIE set: x_irq_o=1. Writing mip=0 clears MTIP and drops x_irq_o. Tick coincident with the mip=0 write: MTIP stays 1.
5. Exception, mret and CSR write presented while x_stall_i=1, and again with x_kill_i=1: no CSR changes in either case. Releasing the stall with the inputs still held applies the trap entry exactly once.
6. Both external and timer interrupts pending and enabled when x_irq_ack_i is pulsed: mcause=0x8000000B. Asserting rst_i mid-pending returns all CSRs to 0 and x_irq_o to 0 on the next edge.

Source files
------------

// File: rtl/rv_trap_ctrl.sv
// Machine-mode trap CSRs (mstatus, mie, mip, mepc, mcause) with trap entry/mret sequencing and IRQ request.
// CSR, trap and mret updates land on the next edge when X is neither stalled nor killed; x_irq_o is registered.
module rv_trap_ctrl #(
  parameter logic [31:0] TRAP_VECTOR = 32'h00000008
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic        d_is_csr_i,
  input  logic [11:0] d_csr_sel_i,
  input  logic [31:0] x_csr_write_value_i,
  input  logic        x_exception_i,
  input  logic [3:0]  x_exception_cause_i,
  input  logic [31:0] x_pc_i,
  input  logic        x_irq_ack_i,
  input  logic        x_is_mret_i,
  input  logic        irq_i,
  input  logic        timer_tick_i,
  output logic        x_irq_o,
  output logic [31:0] x_trap_vector_o,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  logic        irq_s1_q, irq_s2_q;
  logic        st_mie_q, st_mie_d;
  logic        st_mpie_q, st_mpie_d;
  logic        mtie_q, mtie_d;
  logic        meie_q, meie_d;
  logic        mtip_q, mtip_d;
  logic [31:0] mepc_q, mepc_d;
  logic        mcause_int_q, mcause_int_d;
  logic [3:0]  mcause_code_q, mcause_code_d;
  logic        x_irq_q, x_irq_d;

  logic en, trap_entry, mret_go, csr_go, ext_pending, tmr_pending;

  assign ext_pending = irq_s2_q && meie_q;
  assign tmr_pending = mtip_q && mtie_q;

  always_comb begin
    st_mie_d      = st_mie_q;
    st_mpie_d     = st_mpie_q;
    mtie_d        = mtie_q;
    meie_d        = meie_q;
    mtip_d        = mtip_q;
    mepc_d        = mepc_q;
    mcause_int_d  = mcause_int_q;
    mcause_code_d = mcause_code_q;

    en         = !x_stall_i && !x_kill_i;
    trap_entry = en && (x_exception_i || x_irq_ack_i);
    mret_go    = en && x_is_mret_i && !trap_entry;
    csr_go     = en && d_is_csr_i && !trap_entry && !mret_go;

    if (trap_entry) begin
      mepc_d    = {x_pc_i[31:2], 2'b00};
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
      if (x_exception_i) begin
        mcause_int_d  = 1'b0;
        mcause_code_d = x_exception_cause_i;
      end else begin
        // An ack without a visible request still enters; fall back to the timer code.
        mcause_int_d  = 1'b1;
        mcause_code_d = ext_pending ? 4'd11 : 4'd7;
      end
    end else if (mret_go) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end else if (csr_go) begin
      case (d_csr_sel_i)
        ADDR_MSTATUS: begin
          st_mie_d  = x_csr_write_value_i[3];
          st_mpie_d = x_csr_write_value_i[7];
        end
        ADDR_MIE: begin
          mtie_d = x_csr_write_value_i[7];
          meie_d = x_csr_write_value_i[11];
        end
        ADDR_MEPC: mepc_d = {x_csr_write_value_i[31:2], 2'b00};
        ADDR_MCAUSE: begin
          mcause_int_d  = x_csr_write_value_i[31];
          mcause_code_d = x_csr_write_value_i[3:0];
        end
        ADDR_MIP: if (!x_csr_write_value_i[7]) mtip_d = 1'b0;
        default: ;
      endcase
    end

    if (timer_tick_i) mtip_d = 1'b1;

    x_irq_d = st_mie_q && (ext_pending || tmr_pending);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_s1_q      <= 1'b0;
      irq_s2_q      <= 1'b0;
      st_mie_q      <= 1'b0;
      st_mpie_q     <= 1'b0;
      mtie_q        <= 1'b0;
      meie_q        <= 1'b0;
      mtip_q        <= 1'b0;
      mepc_q        <= 32'h0;
      mcause_int_q  <= 1'b0;
      mcause_code_q <= 4'h0;
      x_irq_q       <= 1'b0;
    end else begin
      irq_s1_q      <= irq_i;
      irq_s2_q      <= irq_s1_q;
      st_mie_q      <= st_mie_d;
      st_mpie_q     <= st_mpie_d;
      mtie_q        <= mtie_d;
      meie_q        <= meie_d;
      mtip_q        <= mtip_d;
      mepc_q        <= mepc_d;
      mcause_int_q  <= mcause_int_d;
      mcause_code_q <= mcause_code_d;
      x_irq_q       <= x_irq_d;
    end
  end

  assign x_irq_o         = x_irq_q;
  assign x_trap_vector_o = TRAP_VECTOR;
  assign csr_mstatus_o   = {24'h0, st_mpie_q, 3'b000, st_mie_q, 3'b000};
  assign csr_mie_o       = {20'h0, meie_q, 3'b000, mtie_q, 7'h00};
  assign csr_mip_o       = {20'h0, irq_s2_q, 3'b000, mtip_q, 7'h00};
  assign csr_mepc_o      = mepc_q;
  assign csr_mcause_o    = {mcause_int_q, 27'h0, mcause_code_q};

endmodule

// File: tb/tb_rv_trap_ctrl.sv
// Bench for rv_trap_ctrl: directed scenarios plus random traffic, every cycle checked against a CSR-level model.
module tb_rv_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, kill, is_csr, exc, ack, is_mret, irq, tick;
  logic [11:0] sel;
  logic [31:0] wval, pc;
  logic [3:0]  cause;
  logic        x_irq;
  logic [31:0] tvec, mstatus, mie, mip, mepc, mcause;

  int n_vec = 0;
  int n_err = 0;

  // Model state held as architectural 32-bit CSR images.
  logic [31:0] m_mstatus, m_mie, m_mepc, m_mcause;
  logic        m_mtip, m_irq;
  logic        m_sync [2];

  rv_trap_ctrl #(.TRAP_VECTOR(32'h00000008)) dut (
    .clk_i(clk), .rst_i(rst), .x_stall_i(stall), .x_kill_i(kill),
    .d_is_csr_i(is_csr), .d_csr_sel_i(sel), .x_csr_write_value_i(wval),
    .x_exception_i(exc), .x_exception_cause_i(cause), .x_pc_i(pc),
    .x_irq_ack_i(ack), .x_is_mret_i(is_mret), .irq_i(irq), .timer_tick_i(tick),
    .x_irq_o(x_irq), .x_trap_vector_o(tvec), .csr_mstatus_o(mstatus),
    .csr_mie_o(mie), .csr_mip_o(mip), .csr_mepc_o(mepc), .csr_mcause_o(mcause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_mip();
    return (m_sync[1] ? 32'h800 : 32'h0) | (m_mtip ? 32'h80 : 32'h0);
  endfunction

  task automatic model_edge();
    logic en, trap, mret, wr;
    logic [31:0] nstat, nmie, nepc, ncause;
    logic ntip;
    if (rst) begin
      m_mstatus = 0; m_mie = 0; m_mepc = 0; m_mcause = 0;
      m_mtip = 0; m_irq = 0; m_sync[0] = 0; m_sync[1] = 0;
      return;
    end
    en   = !stall && !kill;
    trap = en && (exc || ack);
    mret = en && is_mret && !trap;
    wr   = en && is_csr && !trap && !mret;
    nstat = m_mstatus; nmie = m_mie; nepc = m_mepc; ncause = m_mcause; ntip = m_mtip;
    if (trap) begin
      nepc  = pc & ~32'h3;
      nstat = m_mstatus[3] ? 32'h80 : 32'h0;
      if (exc) ncause = {28'h0, cause};
      else     ncause = (m_sync[1] && m_mie[11]) ? 32'h8000000B : 32'h80000007;
    end else if (mret) begin
      nstat = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end else if (wr) begin
      if (sel == 12'h300) nstat  = wval & 32'h88;
      if (sel == 12'h304) nmie   = wval & 32'h880;
      if (sel == 12'h341) nepc   = wval & ~32'h3;
      if (sel == 12'h342) ncause = wval & 32'h8000000F;
      if (sel == 12'h344 && !wval[7]) ntip = 1'b0;
    end
    if (tick) ntip = 1'b1;
    m_irq = m_mstatus[3] && ((m_mip() & m_mie) != 0);
    m_mstatus = nstat; m_mie = nmie; m_mepc = nepc; m_mcause = ncause; m_mtip = ntip;
    m_sync[1] = m_sync[0];
    m_sync[0] = irq;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("mstatus", mstatus, m_mstatus);
    chk("mie", mie, m_mie);
    chk("mip", mip, m_mip());
    chk("mepc", mepc, m_mepc);
    chk("mcause", mcause, m_mcause);
    chk("x_irq", {31'h0, x_irq}, {31'h0, m_irq});
  endtask

  task automatic clr();
    rst = 0; stall = 0; kill = 0; is_csr = 0; exc = 0; ack = 0;
    is_mret = 0; tick = 0; sel = 0; wval = 0; pc = 0; cause = 0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] v);
    clr(); is_csr = 1; sel = a; wval = v;
    step();
    clr();
  endtask

  logic [11:0] sels [6];
  logic [31:0] s_stat, s_mie, s_epc, s_cause;

  initial begin
    sels = '{12'h300, 12'h304, 12'h341, 12'h342, 12'h344, 12'h305};
    clr(); irq = 0; rst = 1;
    step();
    rst = 0;
    chk("rst_mstatus", mstatus, 32'h0);
    chk("rst_mcause", mcause, 32'h0);
    chk("rst_irq", {31'h0, x_irq}, 32'h0);
    chk("trap_vector", tvec, 32'h00000008);

    // Write-all-ones masking
    csr_wr(12'h300, 32'hFFFFFFFF); chk("p1_mstatus", mstatus, 32'h88);
    csr_wr(12'h304, 32'hFFFFFFFF); chk("p1_mie", mie, 32'h880);
    csr_wr(12'h341, 32'hFFFFFFFF); chk("p1_mepc", mepc, 32'hFFFFFFFC);
    csr_wr(12'h344, 32'hFFFFFFFF); chk("p1_mip", mip, 32'h0);

    // External interrupt latency and entry
    csr_wr(12'h300, 32'h8); csr_wr(12'h304, 32'h800);
    irq = 1;
    step(); chk("p2_meip_c1", mip, 32'h0);
    step(); chk("p2_meip_c2", mip, 32'h800); chk("p2_irq_c2", {31'h0, x_irq}, 32'h0);
    step(); chk("p2_irq_c3", {31'h0, x_irq}, 32'h1);
    ack = 1; pc = 32'h1236; step(); clr();
    chk("p2_mepc", mepc, 32'h1234); chk("p2_mcause", mcause, 32'h8000000B);
    chk("p2_mstatus", mstatus, 32'h80);
    step(); chk("p2_irq_drop", {31'h0, x_irq}, 32'h0);
    irq = 0; step(); step(); step();

    // Exception beats simultaneous ack; mret restores MIE
    csr_wr(12'h300, 32'h8);
    exc = 1; cause = 4'd2; pc = 32'h100; ack = 1; step(); clr();
    chk("p3_mcause", mcause, 32'h2); chk("p3_mepc", mepc, 32'h100);
    is_mret = 1; step(); clr();
    chk("p3_mret", mstatus, 32'h88);

    // Timer: sticky MTIP, clear by write, tick wins over clear
    csr_wr(12'h304, 32'h80); csr_wr(12'h300, 32'h8);
    tick = 1; step(); clr(); chk("p4_mtip", mip, 32'h80);
    step(); chk("p4_irq", {31'h0, x_irq}, 32'h1);
    csr_wr(12'h344, 32'h0); chk("p4_clr", mip, 32'h0);
    step(); chk("p4_irq_drop", {31'h0, x_irq}, 32'h0);
    is_csr = 1; sel = 12'h344; wval = 0; tick = 1; step(); clr();
    chk("p4_tick_wins", mip, 32'h80);
    csr_wr(12'h344, 32'h0);

    // Stall and kill block all updates; release applies trap once
    csr_wr(12'h300, 32'h8);
    s_stat = m_mstatus; s_mie = m_mie; s_epc = m_mepc; s_cause = m_mcause;
    exc = 1; cause = 4'd5; pc = 32'h203; is_mret = 1; is_csr = 1; sel = 12'h304; wval = 32'h880;
    stall = 1; step(); step();
    chk("p5_stall_stat", mstatus, s_stat); chk("p5_stall_epc", mepc, s_epc);
    stall = 0; kill = 1; step(); step();
    chk("p5_kill_cause", mcause, s_cause); chk("p5_kill_mie", mie, s_mie);
    kill = 0; step(); clr();
    chk("p5_rel_epc", mepc, 32'h200); chk("p5_rel_cause", mcause, 32'h5);
    step(); chk("p5_once", mstatus, 32'h80);

    // Both pending: external priority, then reset mid-pending
    csr_wr(12'h304, 32'h880); csr_wr(12'h300, 32'h8);
    irq = 1; tick = 1; step(); clr(); step(); step();
    ack = 1; pc = 32'h400; step(); clr();
    chk("p6_prio", mcause, 32'h8000000B);
    csr_wr(12'h300, 32'h8); step();
    rst = 1; step(); rst = 0;
    chk("p6_rst_mip", mip, 32'h0); chk("p6_rst_irq", {31'h0, x_irq}, 32'h0);
    chk("p6_rst_mepc", mepc, 32'h0);
    irq = 0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      clr();
      rst     = ($urandom_range(0, 299) == 0);
      stall   = ($urandom_range(0, 7) == 0);
      kill    = ($urandom_range(0, 11) == 0);
      is_csr  = ($urandom_range(0, 2) == 0);
      sel     = sels[$urandom_range(0, 5)];
      wval    = $urandom();
      exc     = ($urandom_range(0, 15) == 0);
      cause   = 4'($urandom());
      pc      = $urandom();
      ack     = x_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      is_mret = ($urandom_range(0, 9) == 0);
      tick    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) irq = ~irq;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
